pcs_tx_mlane: RTL and testbench

PCS_TX_MLANE -- requirements
Module: pcs_tx_mlane

---
 rtl/pcs_tx_mlane.sv | 167 ++++++++++++++++
 tb/tb_pcs_tx_mlane.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_tx_mlane.sv
// pcs_tx_mlane: multi-lane 64b/66b PCS transmit stage.
// Scrambles the payloads of LANE_N encoded blocks per cycle using one shared
// x^58+x^39+1 scrambler. Sync headers pass through unscrambled.
// Optionally inserts per-lane alignment markers carrying BIP3/BIP7.
//
// Build option:
//   PCS_TX_MLANE_AM_EN  defined   -> alignment markers, BIP, ready_o backpressure
//                       undefined -> plain scrambled stream, am_o=0, ready_o=1
//
// Ports:
//   clk      in   clock, all state on rising edge
//   reset    in   synchronous active-high reset
//   valid_i  in   blocks present on head_i/data_i
//   head_i   in   LANE_N sync headers, lane l at [l*HEAD_W +: HEAD_W]
//   data_i   in   LANE_N unscrambled payloads, lane l at [l*DATA_W +: DATA_W]
//   ready_o  out  transfer accepted this cycle when valid_i=1
//   valid_o  out  data_o carries blocks for the gearbox
//   am_o     out  data_o carries alignment markers
//   data_o   out  lane l at [l*66 +: 66] = {payload, header}
module pcs_tx_mlane #(
   parameter int                   LANE_N   = 4,
   parameter int                   DATA_W   = 64,
   parameter int                   HEAD_W   = 2,
   parameter int                   AM_GAP   = 16383,
   parameter logic [LANE_N*24-1:0] AM_TABLE = {24'h3D79A2, 24'h9B65C5, 24'hE6C4F0, 24'h477690}
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              valid_i,
   input  logic [LANE_N*HEAD_W-1:0]          head_i,
   input  logic [LANE_N*DATA_W-1:0]          data_i,
   output logic                              ready_o,
   output logic                              valid_o,
   output logic                              am_o,
   output logic [LANE_N*(DATA_W+HEAD_W)-1:0] data_o
);

   localparam int BLK_W = DATA_W + HEAD_W;
   localparam int PAY_N = LANE_N * DATA_W;

   logic [57:0]             scr_q;
   logic [57:0]             scr_nxt;
   logic [PAY_N-1:0]        scr_data;
   logic [LANE_N*BLK_W-1:0] tx_blk;
   logic [LANE_N*BLK_W-1:0] data_q;
   logic [LANE_N*BLK_W-1:0] data_d;
   logic                    valid_q, valid_d;
   logic                    am_q, am_d;
   logic                    xfer;

   // Serial scrambler unrolled over every payload bit of the cycle, lane 0
   // bit 0 first; s[0] holds the most recent scrambled bit.
   always_comb begin
      logic [57:0] s;
      logic        o;
      s        = scr_q;
      o        = 1'b0;
      scr_data = '0;
      for (int b = 0; b < PAY_N; b++) begin
         o           = data_i[b] ^ s[38] ^ s[57];
         scr_data[b] = o;
         s           = {s[56:0], o};
      end
      scr_nxt = s;
   end

   always_comb begin
      tx_blk = '0;
      for (int l = 0; l < LANE_N; l++)
         tx_blk[l*BLK_W +: BLK_W] = {scr_data[l*DATA_W +: DATA_W], head_i[l*HEAD_W +: HEAD_W]};
   end

`ifdef PCS_TX_MLANE_AM_EN
   logic [13:0]             gap_q, gap_d;
   logic [LANE_N*8-1:0]     bip_q, bip_d;
   logic [LANE_N*BLK_W-1:0] am_blk;
   logic                    am_slot;

   // BIP3 contribution of one 66b block; header bits fold into bits 3 and 4.
   function automatic logic [7:0] bip_of(input logic [BLK_W-1:0] blk);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = 1'b0;
         for (int k = 0; k < 8; k++)
            r[i] = r[i] ^ blk[2+i+8*k];
      end
      r[3] = r[3] ^ blk[0];
      r[4] = r[4] ^ blk[1];
      return r;
   endfunction

   assign am_slot = (gap_q == 14'(AM_GAP));
   assign ready_o = ~reset & ~am_slot;
   assign xfer    = valid_i & ready_o;

   // Payload bytes 0..7 = M0,M1,M2,BIP3,~M0,~M1,~M2,~BIP3 (byte 0 in bits [7:0]).
   always_comb begin
      am_blk = '0;
      for (int l = 0; l < LANE_N; l++)
         am_blk[l*BLK_W +: BLK_W] = {~bip_q[l*8 +: 8], ~AM_TABLE[l*24 +: 24],
                                     bip_q[l*8 +: 8], AM_TABLE[l*24 +: 24], 2'b01};
   end

   always_comb begin
      gap_d   = gap_q;
      bip_d   = bip_q;
      data_d  = data_q;
      valid_d = 1'b0;
      am_d    = 1'b0;
      if (am_slot) begin
         valid_d = 1'b1;
         am_d    = 1'b1;
         data_d  = am_blk;
         gap_d   = '0;
         // the marker opens the next BIP period
         for (int l = 0; l < LANE_N; l++)
            bip_d[l*8 +: 8] = bip_of(am_blk[l*BLK_W +: BLK_W]);
      end else if (xfer) begin
         valid_d = 1'b1;
         data_d  = tx_blk;
         gap_d   = gap_q + 14'd1;
         for (int l = 0; l < LANE_N; l++)
            bip_d[l*8 +: 8] = bip_q[l*8 +: 8] ^ bip_of(tx_blk[l*BLK_W +: BLK_W]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gap_q <= '0;
         bip_q <= '0;
      end else begin
         gap_q <= gap_d;
         bip_q <= bip_d;
      end
   end
`else
   assign ready_o = ~reset;
   assign xfer    = valid_i & ~reset;

   always_comb begin
      valid_d = xfer;
      am_d    = 1'b0;
      data_d  = xfer ? tx_blk : data_q;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         am_q    <= 1'b0;
         data_q  <= '0;
         scr_q   <= 58'h3FF_FFFF_FFFF_FFFF;
      end else begin
         valid_q <= valid_d;
         am_q    <= am_d;
         data_q  <= data_d;
         if (xfer)
            scr_q <= scr_nxt;
      end
   end

   // Outputs are forced low while reset is held, even before the first edge.
   assign valid_o = valid_q & ~reset;
   assign am_o    = am_q & ~reset;
   assign data_o  = reset ? '0 : data_q;

endmodule

// File: tb/tb_pcs_tx_mlane.sv
module tb_pcs_tx_mlane;

`ifdef PCS_TX_MLANE_AM_EN
   localparam bit AM_EN = 1'b1;
`else
   localparam bit AM_EN = 1'b0;
`endif
   localparam int          GAP    = 3;
   localparam logic [95:0] AM_TBL = {24'h3D79A2, 24'h9B65C5, 24'hE6C4F0, 24'h682190};

   logic         clk, reset;
   logic         valid0, valid1;
   logic [7:0]   head0;
   logic [255:0] data0;
   logic [1:0]   head1;
   logic [63:0]  data1;
   logic         ready_o0, valid_o0, am_o0;
   logic [263:0] data_o0;
   logic         ready_o1, valid_o1, am_o1;
   logic [65:0]  data_o1;

   typedef struct packed {
      logic         am;
      logic [263:0] blk;
   } exp_t;

   exp_t        q0[$];
   logic [65:0] q1[$];
   int          n_chk = 0;
   int          n_err = 0;

   logic [57:0] m_scr0, m_scr1;
   logic [7:0]  m_bip[4];
   int          m_gap;
   int          n1;
   int          idx;

   pcs_tx_mlane #(.LANE_N(4), .AM_GAP(GAP), .AM_TABLE(AM_TBL)) u0 (
      .clk(clk), .reset(reset), .valid_i(valid0), .head_i(head0), .data_i(data0),
      .ready_o(ready_o0), .valid_o(valid_o0), .am_o(am_o0), .data_o(data_o0));

   pcs_tx_mlane #(.LANE_N(1), .AM_TABLE(24'h477690)) u1 (
      .clk(clk), .reset(reset), .valid_i(valid1), .head_i(head1), .data_i(data1),
      .ready_o(ready_o1), .valid_o(valid_o1), .am_o(am_o1), .data_o(data_o1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [271:0] act, input logic [271:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference scrambler, newest bit kept at index 57.
   task automatic scr_model(input logic [255:0] din, input int nbits, input logic [57:0] st_in,
                            output logic [57:0] st_out, output logic [255:0] dout);
      logic [57:0] st;
      logic        o;
      st   = st_in;
      dout = '0;
      for (int b = 0; b < nbits; b++) begin
         o       = din[b] ^ st[19] ^ st[0];
         dout[b] = o;
         st      = {o, st[57:1]};
      end
      st_out = st;
   endtask

   function automatic logic [7:0] bip_model(input logic [65:0] blk);
      logic [7:0] r;
      r = 8'h00;
      for (int j = 0; j < 8; j++) r = r ^ blk[2+8*j +: 8];
      r = r ^ {3'b000, blk[1], blk[0], 3'b000};
      return r;
   endfunction

   function automatic logic [63:0] pat(input int i, input int l);
      logic [63:0] p;
      case ((i + l) % 4)
         0:       p = 64'h0000_0000_0000_0000;
         1:       p = 64'hFFFF_FFFF_FFFF_FFFF;
         2:       p = 64'h0123_4567_89AB_CDEF;
         default: p = 64'hA5A5_5A5A_F00F_0FF0;
      endcase
      return p ^ {56'h0, 8'(i)};
   endfunction

   function automatic logic [1:0] hd(input int i, input int l);
      return (((i + l) % 2) == 1) ? 2'b01 : 2'b10;
   endfunction

   // One input cycle: drive at negedge, then push the expected response.
   task automatic cyc(input bit v0, input bit rst, input bit v1);
      logic [255:0] sd;
      logic [57:0]  ns;
      logic [65:0]  b;
      logic         exp_rdy;
      exp_t         e;
      @(negedge clk);
      reset  = rst;
      valid0 = v0;
      valid1 = v1;
      for (int l = 0; l < 4; l++) begin
         data0[l*64 +: 64] = pat(idx, l);
         head0[l*2 +: 2]   = hd(idx, l);
      end
      idx++;
      #1;
      exp_rdy = !rst && !(AM_EN && m_gap == GAP);
      check("ready0", {271'h0, ready_o0}, {271'h0, exp_rdy});
      if (rst) begin
         m_scr0 = '1;
         m_gap  = 0;
         for (int l = 0; l < 4; l++) m_bip[l] = 8'h00;
      end else if (!exp_rdy) begin
         e.am = 1'b1;
         for (int l = 0; l < 4; l++) begin
            b = {~m_bip[l], ~AM_TBL[l*24 +: 24], m_bip[l], AM_TBL[l*24 +: 24], 2'b01};
            e.blk[l*66 +: 66] = b;
            m_bip[l] = bip_model(b);
         end
         q0.push_back(e);
         m_gap = 0;
      end else if (v0) begin
         scr_model(data0, 256, m_scr0, ns, sd);
         m_scr0 = ns;
         e.am   = 1'b0;
         for (int l = 0; l < 4; l++) begin
            b = {sd[l*64 +: 64], head0[l*2 +: 2]};
            e.blk[l*66 +: 66] = b;
            m_bip[l] = m_bip[l] ^ bip_model(b);
         end
         q0.push_back(e);
         m_gap = m_gap + int'(AM_EN);
      end
      if (rst) begin
         m_scr1 = '1;
         n1     = 0;
      end else if (v1) begin
         check("ready1", {271'h0, ready_o1}, 272'h1);
         scr_model({192'h0, data1}, 64, m_scr1, ns, sd);
         m_scr1 = ns;
         // first block from the all-ones state: scrambled bits 39..57 set
         if (n1 == 0) q1.push_back({64'h03FF_FF80_0000_0000, 2'b10});
         else         q1.push_back({sd[63:0], head1});
         n1++;
      end
   endtask

   always @(posedge clk) begin
      exp_t        e;
      logic [65:0] e1;
      #1;
      if (reset) begin
         check("rst_out0", {4'h0, ready_o0, valid_o0, am_o0, data_o0}, '0);
         check("rst_out1", {203'h0, ready_o1, valid_o1, am_o1, data_o1}, '0);
      end else begin
         if (valid_o0 || q0.size() != 0) begin
            if (q0.size() == 0) begin
               check("unexpected_out0", {271'h0, valid_o0}, '0);
            end else begin
               e = q0.pop_front();
               check("valid0", {271'h0, valid_o0}, 272'h1);
               if (valid_o0) begin
                  check("am0", {271'h0, am_o0}, {271'h0, e.am});
                  check("data0", {8'h0, data_o0}, {8'h0, e.blk});
                  if (e.am) begin
                     check("am_lane0_hdr", {270'h0, data_o0[1:0]}, {270'h0, 2'b01});
                     check("am_lane0_bytes", {224'h0, data_o0[57:34], data_o0[25:2]},
                           {224'h0, 24'h97DE6F, 24'h682190});
                  end
               end
            end
         end
         if (valid_o1 || q1.size() != 0) begin
            if (q1.size() == 0) begin
               check("unexpected_out1", {271'h0, valid_o1}, '0);
            end else begin
               e1 = q1.pop_front();
               check("valid1", {271'h0, valid_o1}, 272'h1);
               if (valid_o1) begin
                  check("am1", {271'h0, am_o1}, '0);
                  check("data1", {206'h0, data_o1}, {206'h0, e1});
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b1;
      valid0 = 1'b0;
      valid1 = 1'b0;
      head0  = '0;
      data0  = '0;
      head1  = 2'b10;
      data1  = 64'h0;
      m_scr0 = '1;
      m_scr1 = '1;
      m_gap  = 0;
      n1     = 0;
      idx    = 0;
      for (int l = 0; l < 4; l++) m_bip[l] = 8'h00;

      repeat (3) cyc(1'b0, 1'b1, 1'b0);

      // contiguous stream: two marker periods; LANE_N=1 instance takes 3 blocks
      for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, i < 3);
      repeat (2) cyc(1'b0, 1'b0, 1'b0);

      // valid toggling: idles must not advance gap, BIP or scrambler
      for (int i = 0; i < 12; i++) cyc((i % 2) == 0, 1'b0, 1'b0);

      // fresh reset, then reset asserted exactly in the marker slot
      repeat (2) cyc(1'b0, 1'b1, 1'b0);
      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      repeat (2) cyc(1'b1, 1'b1, 1'b0);
      repeat (6) cyc(1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);

      @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
